// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared register indices, line numbering and vector type for irq_ctrl
package irq_pkg;

  localparam logic [2:0] IRQ_REG_PENDING = 3'd0;
  localparam logic [2:0] IRQ_REG_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_REG_MODE    = 3'd2;
  localparam logic [2:0] IRQ_REG_COUNT   = 3'd3;
  localparam logic [2:0] IRQ_REG_COMPARE = 3'd4;

  localparam int IRQ_TIMER_LINE = 7;
  localparam int IRQ_NUM_EXT    = 7;

  typedef logic [7:0] irq_vec_t;

endpackage

// File: rtl/irq_line.sv
// rtl/irq_line.sv - one external request line: optional synchronizer, edge history, PENDING bit
// Build option: IRQ_SYNC_EN inserts a 2-flop synchronizer ahead of the edge/level logic.
module irq_line (
  input  logic clock,
  input  logic reset,
  input  logic irq_i,
  input  logic mode_i,
  input  logic w1c_i,
  output logic pend_d_o,
  output logic pend_q_o
);

  logic irq_s;
  logic hist_q;
  logic pend_q;
  logic pend_d;

`ifdef IRQ_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_i;
`endif

  // Edge mode is sticky with set winning over W1C; level mode just mirrors the input.
  always_comb begin
    pend_d = irq_s;
    if (mode_i) begin
      pend_d = (irq_s & ~hist_q) | (pend_q & ~w1c_i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      hist_q <= irq_s;
      pend_q <= pend_d;
    end
  end

  assign pend_d_o = pend_d;
  assign pend_q_o = pend_q;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - MMIO interrupt controller: 7 edge/level lines plus COUNT/COMPARE timer on line 7
// Build option: IRQ_SYNC_EN (handled inside irq_line) synchronizes irq_in for asynchronous sources.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          TIMER_DIV   = 1,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic        wr_en,
  input  logic [5:0]  addr,
  input  logic [63:0] wr_data,
  output logic [63:0] rd_data,
  input  logic [6:0]  irq_in,
  output logic [7:0]  interrupt_source
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

  logic [2:0] reg_idx;
  logic       wr;
  logic       wr_enable;
  logic       wr_mode;
  logic       wr_count;
  logic       wr_compare;
  irq_vec_t   w1c_vec;

  irq_vec_t   pend_q;
  irq_vec_t   pend_d;
  logic [6:0] line_pend_q;
  logic [6:0] line_pend_d;
  logic       timer_pend_q;
  logic       timer_pend_d;

  irq_vec_t   en_q;
  irq_vec_t   en_d;
  logic [6:0] mode_q;
  logic [6:0] mode_d;
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic [31:0] compare_q;
  logic [31:0] compare_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic       match;
  logic       match_q;
  logic       timer_set;
  logic       timer_clr;
  irq_vec_t   irq_out_q;

  logic       unused_bits;
  assign unused_bits = ^{wr_data[63:32], addr[2:0]};

  assign reg_idx    = addr[5:3];
  assign wr         = sel & wr_en;
  assign wr_enable  = wr && (reg_idx == IRQ_REG_ENABLE);
  assign wr_mode    = wr && (reg_idx == IRQ_REG_MODE);
  assign wr_count   = wr && (reg_idx == IRQ_REG_COUNT);
  assign wr_compare = wr && (reg_idx == IRQ_REG_COMPARE);
  assign w1c_vec    = (wr && (reg_idx == IRQ_REG_PENDING)) ? wr_data[7:0] : '0;

  for (genvar gi = 0; gi < IRQ_NUM_EXT; gi++) begin : g_line
    irq_line u_line (
      .clock    (clock),
      .reset    (reset),
      .irq_i    (irq_in[gi]),
      .mode_i   (mode_q[gi]),
      .w1c_i    (w1c_vec[gi]),
      .pend_d_o (line_pend_d[gi]),
      .pend_q_o (line_pend_q[gi])
    );
  end

  // Only the first cycle of a match sets the timer line, so a long match under a slow prescaler
  // does not re-raise it after software has cleared it.
  assign match        = (count_q == compare_q);
  assign timer_set    = match & ~match_q;
  assign timer_clr    = w1c_vec[IRQ_TIMER_LINE] | wr_compare;
  assign timer_pend_d = timer_set | (timer_pend_q & ~timer_clr);

  assign pend_q = {timer_pend_q, line_pend_q};
  assign pend_d = {timer_pend_d, line_pend_d};

  always_comb begin
    presc_d   = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    count_d   = (presc_q == PRESC_MAX) ? count_q + 32'd1 : count_q;
    if (wr_count) begin
      count_d = wr_data[31:0];
      presc_d = '0;
    end
    compare_d = wr_compare ? wr_data[31:0] : compare_q;
    en_d      = wr_enable ? wr_data[7:0] : en_q;
    mode_d    = wr_mode ? wr_data[6:0] : mode_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_pend_q <= 1'b0;
      en_q         <= '0;
      mode_q       <= '0;
      count_q      <= '0;
      compare_q    <= COMPARE_RST;
      presc_q      <= '0;
      match_q      <= 1'b0;
      irq_out_q    <= '0;
    end else begin
      timer_pend_q <= timer_pend_d;
      en_q         <= en_d;
      mode_q       <= mode_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      presc_q      <= presc_d;
      match_q      <= match;
      irq_out_q    <= pend_d & en_d;
    end
  end

  assign interrupt_source = irq_out_q;

  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (reg_idx)
        IRQ_REG_PENDING: rd_data = {56'd0, pend_q};
        IRQ_REG_ENABLE:  rd_data = {56'd0, en_q};
        IRQ_REG_MODE:    rd_data = {57'd0, mode_q};
        IRQ_REG_COUNT:   rd_data = {32'd0, count_q};
        IRQ_REG_COMPARE: rd_data = {32'd0, compare_q};
        default:         rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  addr = '0;
  logic [63:0] wr_data = '0;
  logic [63:0] rd_data;
  logic [6:0]  irq_in = '0;
  logic [7:0]  interrupt_source;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  irq_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .sel              (sel),
    .wr_en            (wr_en),
    .addr             (addr),
    .wr_data          (wr_data),
    .rd_data          (rd_data),
    .irq_in           (irq_in),
    .interrupt_source (interrupt_source)
  );

  localparam logic [2:0] R_PEND = 3'd0;
  localparam logic [2:0] R_EN   = 3'd1;
  localparam logic [2:0] R_MODE = 3'd2;
  localparam logic [2:0] R_CNT  = 3'd3;
  localparam logic [2:0] R_CMP  = 3'd4;

  task automatic wr_reg(input logic [2:0] r, input logic [63:0] d);
    @(negedge clock);
    sel = 1'b1; wr_en = 1'b1; addr = {r, 3'b000}; wr_data = d;
    @(negedge clock);
    sel = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
  endtask

  task automatic rd_reg(input logic [2:0] r, output logic [63:0] d);
    sel = 1'b1; wr_en = 1'b0; addr = {r, 3'b000};
    #1;
    d = rd_data;
    sel = 1'b0; addr = '0;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    logic [63:0] exp_r [5];
    exp_r = '{64'd0, 64'd0, 64'd0, 64'd0, 64'h0000_0000_FFFF_FFFF};
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_reg(3'(i), v);
      total++;
      if (v !== exp_r[i]) begin
        bad++;
        $display("FAIL reset_reg%0d got=%h exp=%h", i, v, exp_r[i]);
      end
    end
    rd_reg(3'd7, v);
    total++;
    if (v !== 64'd0) begin
      bad++;
      $display("FAIL reset_reg7 got=%h exp=0", v);
    end
    addr = {R_CMP, 3'b000}; sel = 1'b0;
    #1;
    total++;
    if (rd_data !== 64'd0) begin
      bad++;
      $display("FAIL rd_nosel got=%h exp=0", rd_data);
    end
    addr = '0;
    total++;
    if (interrupt_source !== 8'h00) begin
      bad++;
      $display("FAIL reset_out got=%h exp=00", interrupt_source);
    end
  endtask

  task automatic test_edge();
    logic [63:0] v;
    wr_reg(R_MODE, 64'h01);
    wr_reg(R_EN, 64'h01);
    @(negedge clock); irq_in[0] = 1'b1;
    @(negedge clock); irq_in[0] = 1'b0;
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h01) begin
      bad++;
      $display("FAIL edge_pend got=%h exp=01", v);
    end
    total++;
    if (interrupt_source !== 8'h01) begin
      bad++;
      $display("FAIL edge_out got=%h exp=01", interrupt_source);
    end
    repeat (3) @(negedge clock);
    total++;
    if (interrupt_source !== 8'h01) begin
      bad++;
      $display("FAIL edge_hold got=%h exp=01", interrupt_source);
    end
    wr_reg(R_PEND, 64'h01);
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h00 || interrupt_source !== 8'h00) begin
      bad++;
      $display("FAIL edge_w1c got pend=%h out=%h exp=00/00", v, interrupt_source);
    end
  endtask

  task automatic test_level();
    logic [63:0] v;
    wr_reg(R_MODE, 64'h00);
    wr_reg(R_EN, 64'h04);
    @(negedge clock); irq_in[2] = 1'b1;
    @(negedge clock);
    total++;
    if (interrupt_source !== 8'h04) begin
      bad++;
      $display("FAIL level_out got=%h exp=04", interrupt_source);
    end
    wr_reg(R_PEND, 64'h04);
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h04 || interrupt_source !== 8'h04) begin
      bad++;
      $display("FAIL level_w1c got pend=%h out=%h exp=04/04", v, interrupt_source);
    end
    irq_in[2] = 1'b0;
    @(negedge clock);
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h00 || interrupt_source !== 8'h00) begin
      bad++;
      $display("FAIL level_drop got pend=%h out=%h exp=00/00", v, interrupt_source);
    end
  endtask

  task automatic test_timer();
    logic [63:0] v;
    int first;
    wr_reg(R_CNT, 64'd100);
    wr_reg(R_CMP, 64'd10);
    wr_reg(R_EN, 64'h80);
    wr_reg(R_CNT, 64'd0);
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (interrupt_source[7] && first < 0) first = k;
    end
    total++;
    if (first != 11) begin
      bad++;
      $display("FAIL timer_latency got=%0d exp=11", first);
    end
    rd_reg(R_CNT, v);
    total++;
    if (v !== 64'd20) begin
      bad++;
      $display("FAIL timer_count got=%0d exp=20", v);
    end
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h80) begin
      bad++;
      $display("FAIL timer_pend got=%h exp=80", v);
    end
    wr_reg(R_CMP, 64'd200);
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h00 || interrupt_source !== 8'h00) begin
      bad++;
      $display("FAIL timer_cmp_clr got pend=%h out=%h exp=00/00", v, interrupt_source);
    end
    wr_reg(R_CNT, 64'hFFFF_FFFF);
    rd_reg(R_CNT, v);
    total++;
    if (v !== 64'h0000_0000_FFFF_FFFF) begin
      bad++;
      $display("FAIL timer_wr_count got=%h exp=ffffffff", v);
    end
    @(negedge clock);
    rd_reg(R_CNT, v);
    total++;
    if (v !== 64'd0) begin
      bad++;
      $display("FAIL timer_wrap got=%h exp=0", v);
    end
    wr_reg(R_CMP, 64'hFFFF_FFFF);
    wr_reg(R_EN, 64'h00);
  endtask

  task automatic test_set_vs_w1c();
    logic [63:0] v;
    wr_reg(R_MODE, 64'h02);
    wr_reg(R_EN, 64'h02);
    @(negedge clock);
    sel = 1'b1; wr_en = 1'b1; addr = {R_PEND, 3'b000}; wr_data = 64'h02; irq_in[1] = 1'b1;
    @(negedge clock);
    sel = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0; irq_in[1] = 1'b0;
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h02 || interrupt_source !== 8'h02) begin
      bad++;
      $display("FAIL set_beats_w1c got pend=%h out=%h exp=02/02", v, interrupt_source);
    end
    @(negedge clock);
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h02) begin
      bad++;
      $display("FAIL edge_sticky got=%h exp=02", v);
    end
    wr_reg(R_PEND, 64'h02);
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h00) begin
      bad++;
      $display("FAIL edge_w1c_later got=%h exp=00", v);
    end
  endtask

  task automatic test_mask();
    logic [63:0] v;
    wr_reg(R_MODE, 64'h08);
    wr_reg(R_EN, 64'h00);
    @(negedge clock); irq_in[3] = 1'b1;
    @(negedge clock); irq_in[3] = 1'b0;
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h08 || interrupt_source !== 8'h00) begin
      bad++;
      $display("FAIL mask_pend got pend=%h out=%h exp=08/00", v, interrupt_source);
    end
    wr_reg(R_EN, 64'h08);
    total++;
    if (interrupt_source !== 8'h08) begin
      bad++;
      $display("FAIL unmask_out got=%h exp=08", interrupt_source);
    end
    wr_reg(R_PEND, 64'h08);
  endtask

  task automatic test_mid_reset();
    logic [63:0] v;
    wr_reg(R_MODE, 64'h00);
    irq_in[4] = 1'b1;
    wr_reg(R_EN, 64'h10);
    total++;
    if (interrupt_source !== 8'h10) begin
      bad++;
      $display("FAIL pre_reset_out got=%h exp=10", interrupt_source);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h00 || interrupt_source !== 8'h00) begin
      bad++;
      $display("FAIL async_reset got pend=%h out=%h exp=00/00", v, interrupt_source);
    end
    rd_reg(R_EN, v);
    total++;
    if (v !== 64'h00) begin
      bad++;
      $display("FAIL async_reset_en got=%h exp=00", v);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h00) begin
      bad++;
      $display("FAIL release_pend got=%h exp=00", v);
    end
    @(negedge clock);
    rd_reg(R_PEND, v);
    total++;
    if (v !== 64'h10 || interrupt_source !== 8'h00) begin
      bad++;
      $display("FAIL held_level got pend=%h out=%h exp=10/00", v, interrupt_source);
    end
    irq_in[4] = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_timer();
    test_set_vs_w1c();
    test_mask();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
